// File: rtl/appliance_pkg.sv
// Shared class/field/zone codes, FSM state type and parameter helpers
// for the appliance control hub.
package appliance_pkg;

  localparam logic [1:0] CLS_FRIDGE = 2'd0;
  localparam logic [1:0] CLS_AC     = 2'd1;

  // Field codes overlap between classes; the class decides which applies.
  localparam logic [1:0] F_TEMP    = 2'd0;
  localparam logic [1:0] F_CAP     = 2'd1;
  localparam logic [1:0] F_ICE     = 2'd2;
  localparam logic [1:0] F_FAN     = 2'd2;
  localparam logic [1:0] F_TIMER   = 2'd3;
  localparam logic [1:0] F_FR_RSVD = 2'd3;

  localparam logic Z_FRIDGE  = 1'b0;
  localparam logic Z_FREEZER = 1'b1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_e;

  function automatic int dev_width(input int n_fridge, input int n_ac);
    int n;
    n = (n_fridge > n_ac) ? n_fridge : n_ac;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ac_unit_regs.sv
// Settings registers for one AC unit: write port with temperature clamp,
// plus the minute-driven off-timer that zeroes the fan on expiry.
module ac_unit_regs
  import appliance_pkg::*;
#(
  parameter int VAL_W       = 5,
  parameter int AC_TEMP_MIN = 16,
  parameter int AC_TEMP_MAX = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_field_i,
  input  logic [VAL_W-1:0] wr_data_i,
  input  logic             tick_i,
  output logic [VAL_W-1:0] temp_o,
  output logic [VAL_W-1:0] cap_o,
  output logic [VAL_W-1:0] fan_o,
  output logic [VAL_W-1:0] timer_o,
  output logic             expired_o
);

  localparam logic [VAL_W-1:0] TEMP_MIN = VAL_W'(AC_TEMP_MIN);
  localparam logic [VAL_W-1:0] TEMP_MAX = VAL_W'(AC_TEMP_MAX);

  logic [VAL_W-1:0] temp_q, temp_d;
  logic [VAL_W-1:0] cap_q, cap_d;
  logic [VAL_W-1:0] fan_q, fan_d;
  logic [VAL_W-1:0] timer_q, timer_d;
  logic             expired_q, expired_d;

  function automatic logic [VAL_W-1:0] clamp_temp(input logic [VAL_W-1:0] v);
    if (v < TEMP_MIN) return TEMP_MIN;
    if (v > TEMP_MAX) return TEMP_MAX;
    return v;
  endfunction

  // The timer step is evaluated first so that a same-cycle write overrides it.
  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves it unassigned and infers a latch.
    temp_d    = temp_q;
    cap_d     = cap_q;
    fan_d     = fan_q;
    timer_d   = timer_q;
    expired_d = 1'b0;

    if (tick_i && (timer_q != '0)) begin
      timer_d = timer_q - VAL_W'(1);
      if (timer_q == VAL_W'(1)) begin
        fan_d     = '0;
        expired_d = 1'b1;
      end
    end

    if (wr_en_i) begin
      case (wr_field_i)
        F_TEMP:  temp_d  = clamp_temp(wr_data_i);
        F_CAP:   cap_d   = wr_data_i;
        F_FAN:   fan_d   = wr_data_i;
        F_TIMER: timer_d = wr_data_i;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_q    <= TEMP_MAX;
      cap_q     <= '0;
      fan_q     <= '0;
      timer_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      temp_q    <= temp_d;
      cap_q     <= cap_d;
      fan_q     <= fan_d;
      timer_q   <= timer_d;
      expired_q <= expired_d;
    end
  end

  assign temp_o    = temp_q;
  assign cap_o     = cap_q;
  assign fan_o     = fan_q;
  assign timer_o   = timer_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/appliance_ctrl_hub.sv
// Command hub for a bank of fridges and AC units: two-state handshake FSM,
// command validation, per-device settings registers and AC off-timers.
module appliance_ctrl_hub
  import appliance_pkg::*;
#(
  parameter int NUM_FRIDGE  = 2,
  parameter int NUM_AC      = 2,
  parameter int VAL_W       = 5,
  parameter int AC_TEMP_MIN = 16,
  parameter int AC_TEMP_MAX = 30,
  parameter int DEV_W       = dev_width(NUM_FRIDGE, NUM_AC)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_class,
  input  logic [DEV_W-1:0]            cmd_dev,
  input  logic [1:0]                  cmd_field,
  input  logic                        cmd_zone,
  input  logic [VAL_W-1:0]            cmd_data,
  output logic                        resp_valid,
  output logic                        resp_err,
  input  logic                        tick,
  output logic [NUM_FRIDGE*VAL_W-1:0] fg_temp,
  output logic [NUM_FRIDGE*VAL_W-1:0] fr_temp,
  output logic [NUM_FRIDGE*VAL_W-1:0] fg_cap,
  output logic [NUM_FRIDGE*VAL_W-1:0] fr_cap,
  output logic [NUM_FRIDGE-1:0]       ice,
  output logic [NUM_AC*VAL_W-1:0]     ac_temp,
  output logic [NUM_AC*VAL_W-1:0]     ac_cap,
  output logic [NUM_AC*VAL_W-1:0]     ac_fan,
  output logic [NUM_AC*VAL_W-1:0]     ac_timer,
  output logic [NUM_AC-1:0]           ac_expired
);

  state_e           state_q;
  logic             ready_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic [1:0]       cls_q;
  logic [DEV_W-1:0] dev_q;
  logic [1:0]       field_q;
  logic             zone_q;
  logic [VAL_W-1:0] data_q;

  logic is_fridge;
  logic is_ac;
  logic cmd_err;
  logic fr_wr;
  logic ac_wr;

  always_comb begin
    is_fridge = (cls_q == CLS_FRIDGE);
    is_ac     = (cls_q == CLS_AC);
    cmd_err   = 1'b1;
    if (is_fridge) begin
      cmd_err = (int'(dev_q) >= NUM_FRIDGE) || (field_q == F_FR_RSVD);
    end else if (is_ac) begin
      cmd_err = (int'(dev_q) >= NUM_AC);
    end
    fr_wr = (state_q == S_APPLY) && !cmd_err && is_fridge;
    ac_wr = (state_q == S_APPLY) && !cmd_err && is_ac;
  end

  // cmd_ready is kept as its own flop so it is registered, not decoded from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      cls_q        <= '0;
      dev_q        <= '0;
      field_q      <= '0;
      zone_q       <= 1'b0;
      data_q       <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            cls_q   <= cmd_class;
            dev_q   <= cmd_dev;
            field_q <= cmd_field;
            zone_q  <= cmd_zone;
            data_q  <= cmd_data;
            state_q <= S_APPLY;
            ready_q <= 1'b0;
          end
        end
        S_APPLY: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= cmd_err;
          state_q      <= S_IDLE;
          ready_q      <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

  for (genvar i = 0; i < NUM_FRIDGE; i++) begin : g_fridge
    logic [VAL_W-1:0] fg_temp_q, fr_temp_q, fg_cap_q, fr_cap_q;
    logic             ice_q;
    logic             sel;

    assign sel = fr_wr && (dev_q == DEV_W'(i));

    // NOTE: settings are plain flops, not a RAM, so each one is reset and reads its default straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fg_temp_q <= '0;
        fr_temp_q <= '0;
        fg_cap_q  <= '0;
        fr_cap_q  <= '0;
        ice_q     <= 1'b0;
      end else if (sel) begin
        case (field_q)
          F_TEMP: begin
            if (zone_q == Z_FRIDGE) fg_temp_q <= data_q;
            else                    fr_temp_q <= data_q;
          end
          F_CAP: begin
            if (zone_q == Z_FREEZER) fr_cap_q <= data_q;
            else                     fg_cap_q <= data_q;
          end
          F_ICE:   ice_q <= data_q[0];
          default: ;
        endcase
      end
    end

    assign fg_temp[i*VAL_W +: VAL_W] = fg_temp_q;
    assign fr_temp[i*VAL_W +: VAL_W] = fr_temp_q;
    assign fg_cap[i*VAL_W +: VAL_W]  = fg_cap_q;
    assign fr_cap[i*VAL_W +: VAL_W]  = fr_cap_q;
    assign ice[i]                    = ice_q;
  end

  for (genvar i = 0; i < NUM_AC; i++) begin : g_ac
    logic sel;

    assign sel = ac_wr && (dev_q == DEV_W'(i));

    ac_unit_regs #(
      .VAL_W       (VAL_W),
      .AC_TEMP_MIN (AC_TEMP_MIN),
      .AC_TEMP_MAX (AC_TEMP_MAX)
    ) u_ac (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (sel),
      .wr_field_i (field_q),
      .wr_data_i  (data_q),
      .tick_i     (tick),
      .temp_o     (ac_temp[i*VAL_W +: VAL_W]),
      .cap_o      (ac_cap[i*VAL_W +: VAL_W]),
      .fan_o      (ac_fan[i*VAL_W +: VAL_W]),
      .timer_o    (ac_timer[i*VAL_W +: VAL_W]),
      .expired_o  (ac_expired[i])
    );
  end

endmodule
